// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline hazard, forwarding and ISA-switch drain controller.
// Revision : 1.0
// ============================================================================
module hazard_ctrl #(
  parameter logic        RESET_ARM    = 1'b0,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic [1:0] ResultSrcE,
  input  logic       armE,
  input  logic       PCRedirE,
  input  logic       SwitchE,
  input  logic       ModeTgtE,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushD,
  output logic       FlushE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       armModeF,
  output logic       busy
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  localparam logic [2:0] C_DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

  state_t     r_state;
  logic [2:0] r_cnt;
  logic       r_pend_mode;
  logic       r_arm_mode;
  logic       r_busy;

  logic       w_a_ok;
  logic       w_b_ok;
  logic       w_lw_stall;

  // x0 is hardwired zero only in RISC-V; ARM r0 is a real register
  assign w_a_ok = armE | (Rs1E != 5'd0);
  assign w_b_ok = armE | (Rs2E != 5'd0);

  assign w_lw_stall = (ResultSrcE == 2'b01) && (armE || (RdE != 5'd0)) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

  always_comb begin
    ForwardAE = 2'b00;
    if (RegWriteM && (RdM == Rs1E) && w_a_ok)
      ForwardAE = 2'b10;
    else if (RegWriteW && (RdW == Rs1E) && w_a_ok)
      ForwardAE = 2'b01;
  end

  always_comb begin
    ForwardBE = 2'b00;
    if (RegWriteM && (RdM == Rs2E) && w_b_ok)
      ForwardBE = 2'b10;
    else if (RegWriteW && (RdW == Rs2E) && w_b_ok)
      ForwardBE = 2'b01;
  end

  // A switch or redirect discards the younger instructions, so a stall is moot
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (r_state == ST_DRAIN) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else begin
      StallF = w_lw_stall & ~PCRedirE & ~SwitchE;
      StallD = w_lw_stall & ~PCRedirE & ~SwitchE;
      FlushD = PCRedirE | SwitchE;
      FlushE = w_lw_stall | PCRedirE | SwitchE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_cnt       <= 3'd0;
      r_pend_mode <= RESET_ARM;
      r_arm_mode  <= RESET_ARM;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (SwitchE) begin
            r_pend_mode <= ModeTgtE;
            r_cnt       <= C_DRAIN_LOAD;
            r_busy      <= 1'b1;
            r_state     <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (r_cnt == 3'd0) begin
            r_arm_mode <= r_pend_mode;
            r_busy     <= 1'b0;
            r_state    <= ST_RUN;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  assign armModeF = r_arm_mode;
  assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// Testbench for hazard_ctrl: directed plan followed by randomized traffic
// against a cycle-level behavioural model (two instances: DRAIN_CYCLES 2 and 1).
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, armE, PCRedirE, SwitchE, ModeTgtE;
  logic [1:0] ResultSrcE;

  logic       StallF [2];
  logic       StallD [2];
  logic       FlushD [2];
  logic       FlushE [2];
  logic [1:0] ForwardAE [2];
  logic [1:0] ForwardBE [2];
  logic       armModeF [2];
  logic       busy [2];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // behavioural model: cycles of drain left, current and pending mode
  int   m_left [2];
  logic m_mode [2];
  logic m_pend [2];
  int   dcs    [2];

  always #5 clk = ~clk;

  hazard_ctrl #(.RESET_ARM(1'b0), .DRAIN_CYCLES(2)) u_dut0 (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .armE(armE), .PCRedirE(PCRedirE), .SwitchE(SwitchE),
    .ModeTgtE(ModeTgtE), .StallF(StallF[0]), .StallD(StallD[0]), .FlushD(FlushD[0]),
    .FlushE(FlushE[0]), .ForwardAE(ForwardAE[0]), .ForwardBE(ForwardBE[0]),
    .armModeF(armModeF[0]), .busy(busy[0])
  );

  hazard_ctrl #(.RESET_ARM(1'b0), .DRAIN_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .armE(armE), .PCRedirE(PCRedirE), .SwitchE(SwitchE),
    .ModeTgtE(ModeTgtE), .StallF(StallF[1]), .StallD(StallD[1]), .FlushD(FlushD[1]),
    .FlushE(FlushE[1]), .ForwardAE(ForwardAE[1]), .ForwardBE(ForwardBE[1]),
    .armModeF(armModeF[1]), .busy(busy[1])
  );

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic idle();
    Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
    RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; ResultSrcE = 2'b00;
    armE = 1'b0; PCRedirE = 1'b0; SwitchE = 1'b0; ModeTgtE = 1'b0;
  endtask

  function automatic logic [1:0] fwd(input logic [4:0] src);
    logic ok;
    ok = armE || (src != 5'd0);
    if (RegWriteM && RdM == src && ok) return 2'b10;
    if (RegWriteW && RdW == src && ok) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_init();
    for (int k = 0; k < 2; k++) begin
      m_left[k] = 0; m_mode[k] = 1'b0; m_pend[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (m_left[k] > 0) begin
        m_left[k]--;
        if (m_left[k] == 0) m_mode[k] = m_pend[k];
      end else if (SwitchE) begin
        m_left[k] = dcs[k];
        m_pend[k] = ModeTgtE;
      end
    end
  endtask

  task automatic check_all();
    logic lw, st, fd, fe, bz;
    lw = (ResultSrcE == 2'b01) && (armE || RdE != 5'd0) && (RdE == Rs1D || RdE == Rs2D);
    for (int k = 0; k < 2; k++) begin
      bz = (m_left[k] > 0);
      st = bz ? 1'b0 : (lw && !PCRedirE && !SwitchE);
      fd = bz ? 1'b1 : (PCRedirE || SwitchE);
      fe = bz ? 1'b1 : (lw || PCRedirE || SwitchE);
      chk("rnd_fwdA", ForwardAE[k], fwd(Rs1E));
      chk("rnd_fwdB", ForwardBE[k], fwd(Rs2E));
      chk("rnd_stallF", {1'b0, StallF[k]}, {1'b0, st});
      chk("rnd_stallD", {1'b0, StallD[k]}, {1'b0, st});
      chk("rnd_flushD", {1'b0, FlushD[k]}, {1'b0, fd});
      chk("rnd_flushE", {1'b0, FlushE[k]}, {1'b0, fe});
      chk("rnd_busy", {1'b0, busy[k]}, {1'b0, bz});
      chk("rnd_mode", {1'b0, armModeF[k]}, {1'b0, m_mode[k]});
    end
  endtask

  initial begin
    dcs[0] = 2; dcs[1] = 1;
    idle();
    rst = 1'b1;
    #3;
    chk("rst_busy", {1'b0, busy[0]}, 2'd0);
    chk("rst_mode", {1'b0, armModeF[0]}, 2'd0);
    chk("rst_stall", {1'b0, StallF[0]}, 2'd0);
    chk("rst_flushD", {1'b0, FlushD[0]}, 2'd0);
    chk("rst_flushE", {1'b0, FlushE[0]}, 2'd0);
    @(posedge clk); #1 rst = 1'b0;

    // forwarding priority
    RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5; RegWriteW = 1'b1; RdW = 5'd5;
    #1 chk("fwdA_M", ForwardAE[0], 2'b10);
    RegWriteM = 1'b0;
    #1 chk("fwdA_W", ForwardAE[0], 2'b01);

    // x0 rule
    idle(); RdM = 5'd0; Rs2E = 5'd0; RegWriteM = 1'b1;
    #1 chk("fwdB_x0_rv", ForwardBE[0], 2'b00);
    armE = 1'b1;
    #1 chk("fwdB_r0_arm", ForwardBE[0], 2'b10);

    // load-use
    idle(); ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
    #1;
    chk("lu_stallF", {1'b0, StallF[0]}, 2'd1);
    chk("lu_stallD", {1'b0, StallD[0]}, 2'd1);
    chk("lu_flushE", {1'b0, FlushE[0]}, 2'd1);
    chk("lu_flushD", {1'b0, FlushD[0]}, 2'd0);
    PCRedirE = 1'b1;
    #1;
    chk("lu_redir_stall", {1'b0, StallF[0]}, 2'd0);
    chk("lu_redir_flushD", {1'b0, FlushD[0]}, 2'd1);
    chk("lu_redir_flushE", {1'b0, FlushE[0]}, 2'd1);

    // ISA switch to ARM
    @(posedge clk); #1;
    idle(); SwitchE = 1'b1; ModeTgtE = 1'b1; PCRedirE = 1'b1;
    @(posedge clk); #1;   // edge N
    idle();
    chk("sw_busy0", {1'b0, busy[0]}, 2'd1);
    chk("sw_mode0", {1'b0, armModeF[0]}, 2'd0);
    chk("sw_flushD0", {1'b0, FlushD[0]}, 2'd1);
    chk("sw_flushE0", {1'b0, FlushE[0]}, 2'd1);
    SwitchE = 1'b1; ModeTgtE = 1'b0; ResultSrcE = 2'b01; RdE = 5'd3; Rs1D = 5'd3;
    #1;
    chk("sw_ign_stall", {1'b0, StallF[0]}, 2'd0);
    chk("sw_ign_stallD", {1'b0, StallD[0]}, 2'd0);
    @(posedge clk); #1;   // edge N+1
    chk("sw_busy1", {1'b0, busy[0]}, 2'd1);
    chk("sw_mode1", {1'b0, armModeF[0]}, 2'd0);
    chk("sw_flushD1", {1'b0, FlushD[0]}, 2'd1);
    @(posedge clk); #1;   // edge N+2
    idle();
    chk("sw_busy2", {1'b0, busy[0]}, 2'd0);
    chk("sw_mode2", {1'b0, armModeF[0]}, 2'd1);
    @(posedge clk); #1;
    chk("sw_busy3", {1'b0, busy[0]}, 2'd0);
    chk("sw_mode3", {1'b0, armModeF[0]}, 2'd1);

    // reset mid-drain
    SwitchE = 1'b1; ModeTgtE = 1'b1;
    @(posedge clk); #1;
    idle();
    chk("rd_busy", {1'b0, busy[0]}, 2'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rd_busy_rst", {1'b0, busy[0]}, 2'd0);
    chk("rd_mode_rst", {1'b0, armModeF[0]}, 2'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rd_busy_after", {1'b0, busy[0]}, 2'd0);
    chk("rd_mode_after", {1'b0, armModeF[0]}, 2'd0);

    // randomized traffic against the model
    model_init();
    for (int i = 0; i < 400; i++) begin
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
      RdW  = 5'($urandom_range(0, 3));
      RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
      ResultSrcE = 2'($urandom_range(0, 3));
      armE = 1'($urandom_range(0, 1));
      SwitchE = ($urandom_range(0, 7) == 0);
      ModeTgtE = 1'($urandom_range(0, 1));
      PCRedirE = SwitchE ? 1'b1 : ($urandom_range(0, 3) == 0);
      #4;
      check_all();
      @(posedge clk);
      model_step();
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
